// File: rtl/keypad_pkg.sv
// Shared types and the key map for the multi-tap keypad entry block.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } scan_state_t;

    // size == 0 marks a key that has no letter group
    typedef struct packed {
        logic [7:0] base;
        logic [2:0] size;
    } key_map_t;

    localparam int unsigned KEY_MAP_DEPTH = 16;
    localparam int unsigned KEY_SUBMIT    = 12;
    localparam int unsigned KEY_CLEAR     = 13;

    localparam key_map_t KEY_MAP [KEY_MAP_DEPTH] = '{
        '{base: 8'h41, size: 3'd3},
        '{base: 8'h44, size: 3'd3},
        '{base: 8'h47, size: 3'd3},
        '{base: 8'h4A, size: 3'd3},
        '{base: 8'h4D, size: 3'd3},
        '{base: 8'h50, size: 3'd4},
        '{base: 8'h54, size: 3'd3},
        '{base: 8'h57, size: 3'd4},
        '{base: 8'h00, size: 3'd0},
        '{base: 8'h00, size: 3'd0},
        '{base: 8'h00, size: 3'd0},
        '{base: 8'h00, size: 3'd0},
        '{base: 8'h00, size: 3'd0},
        '{base: 8'h00, size: 3'd0},
        '{base: 8'h00, size: 3'd0},
        '{base: 8'h00, size: 3'd0}
    };

    // Keys beyond the table (large keypads) have no letter group.
    function automatic key_map_t key_lookup(input logic [5:0] idx);
        if (idx < 6'(KEY_MAP_DEPTH)) begin
            return KEY_MAP[idx[3:0]];
        end
        return '0;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Matrix keypad column scanner with press/release debounce; one key_event per debounced press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_ROWS        = 4,
    parameter int unsigned NUM_COLS        = 4,
    parameter int unsigned SCAN_CYCLES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_ROWS-1:0]                   row_in,
    output logic [NUM_COLS-1:0]                   col_out,
    output logic                                  key_event,
    output logic [$clog2(NUM_ROWS*NUM_COLS)-1:0]  key_code
);

    localparam int unsigned KEY_W  = $clog2(NUM_ROWS * NUM_COLS);
    localparam int unsigned COL_W  = $clog2(NUM_COLS);
    localparam int unsigned ROW_W  = $clog2(NUM_ROWS);
    localparam int unsigned SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    scan_state_t         state;
    logic [COL_W-1:0]    col_idx;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [DB_W-1:0]     db_cnt;
    logic [NUM_ROWS-1:0] row_latch;
    logic [ROW_W-1:0]    row_idx_c;

    // Row bit NUM_ROWS-1 is row 0.
    always_comb begin
        row_idx_c = '0;
        for (int unsigned b = 0; b < NUM_ROWS; b++) begin
            if (row_latch[b]) begin
                row_idx_c = ROW_W'(NUM_ROWS - 1 - b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            col_idx   <= '0;
            col_out   <= {1'b1, {(NUM_COLS-1){1'b0}}};
            scan_cnt  <= '0;
            db_cnt    <= '0;
            row_latch <= '0;
            key_event <= 1'b0;
            key_code  <= '0;
        end else begin
            key_event <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (scan_cnt == SCAN_W'(SCAN_CYCLES - 1)) begin
                        scan_cnt <= '0;
                        if ($onehot(row_in)) begin
                            row_latch <= row_in;
                            db_cnt    <= '0;
                            state     <= DEBOUNCE;
                        end else begin
                            col_idx <= (col_idx == COL_W'(NUM_COLS - 1)) ? '0 : col_idx + 1'b1;
                            col_out <= {col_out[0], col_out[NUM_COLS-1:1]};
                        end
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (row_in == row_latch) begin
                        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                            db_cnt <= '0;
                            state  <= PRESSED;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end else begin
                        db_cnt <= '0;
                        state  <= SCAN;
                    end
                end
                PRESSED: begin
                    key_event <= 1'b1;
                    key_code  <= KEY_W'(row_idx_c * NUM_COLS + col_idx);
                    db_cnt    <= '0;
                    state     <= RELEASE;
                end
                RELEASE: begin
                    // Resume scanning at the column after the released key.
                    if (row_in == '0) begin
                        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                            db_cnt   <= '0;
                            scan_cnt <= '0;
                            state    <= SCAN;
                            col_idx  <= (col_idx == COL_W'(NUM_COLS - 1)) ? '0 : col_idx + 1'b1;
                            col_out  <= {col_out[0], col_out[NUM_COLS-1:1]};
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end else begin
                        db_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/multitap_keypad_entry.sv
// Keypad front end: scanner plus multi-tap letter entry with commit, submit and clear strobes.
module multitap_keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_ROWS        = 4,
    parameter int unsigned NUM_COLS        = 4,
    parameter int unsigned SCAN_CYCLES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TAP_TIMEOUT     = 50
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_ROWS-1:0]                   row_in,
    output logic [NUM_COLS-1:0]                   col_out,
    output logic [7:0]                            letter,
    output logic                                  letter_valid,
    output logic                                  submit,
    output logic                                  clear,
    output logic [7:0]                            pending_letter,
    output logic                                  pending_valid,
    output logic [$clog2(NUM_ROWS*NUM_COLS)-1:0]  key_code
);

    localparam int unsigned KEY_W   = $clog2(NUM_ROWS * NUM_COLS);
    localparam int unsigned TIMER_W = $clog2(TAP_TIMEOUT + 1);

    logic               key_event;
    logic [5:0]         key_idx_c;
    key_map_t           map_c;
    logic               is_letter_c;
    logic               is_submit_c;
    logic               is_clear_c;
    logic               timed_out_c;
    logic               same_key_c;
    logic [1:0]         next_tap_c;
    logic [KEY_W-1:0]   pending_key;
    logic [1:0]         tap_idx;
    logic [TIMER_W-1:0] tap_timer;

    keypad_scanner #(
        .NUM_ROWS        (NUM_ROWS),
        .NUM_COLS        (NUM_COLS),
        .SCAN_CYCLES     (SCAN_CYCLES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_event (key_event),
        .key_code  (key_code)
    );

    // A same-key tap arriving exactly at the timeout is treated as a fresh tap.
    always_comb begin
        key_idx_c   = 6'(key_code);
        map_c       = key_lookup(key_idx_c);
        is_letter_c = key_event && (map_c.size != 3'd0);
        is_submit_c = key_event && (key_idx_c == 6'(KEY_SUBMIT));
        is_clear_c  = key_event && (key_idx_c == 6'(KEY_CLEAR));
        timed_out_c = pending_valid && (tap_timer == TIMER_W'(TAP_TIMEOUT));
        same_key_c  = pending_valid && (pending_key == key_code) && !timed_out_c;
        next_tap_c  = ((3'(tap_idx) + 3'd1) == map_c.size) ? 2'd0 : tap_idx + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            letter         <= '0;
            letter_valid   <= 1'b0;
            submit         <= 1'b0;
            clear          <= 1'b0;
            pending_letter <= '0;
            pending_valid  <= 1'b0;
            pending_key    <= '0;
            tap_idx        <= '0;
            tap_timer      <= '0;
        end else begin
            letter_valid <= 1'b0;
            submit       <= 1'b0;
            clear        <= 1'b0;
            if (pending_valid && !timed_out_c) begin
                tap_timer <= tap_timer + 1'b1;
            end

            if (is_letter_c) begin
                tap_timer <= '0;
                if (same_key_c) begin
                    tap_idx        <= next_tap_c;
                    pending_letter <= map_c.base + 8'(next_tap_c);
                end else begin
                    if (pending_valid) begin
                        letter       <= pending_letter;
                        letter_valid <= 1'b1;
                    end
                    pending_key    <= key_code;
                    tap_idx        <= '0;
                    pending_letter <= map_c.base;
                    pending_valid  <= 1'b1;
                end
            end else if (is_submit_c || is_clear_c || timed_out_c) begin
                // Clear drops the pending letter unless it had already timed out.
                if (timed_out_c || (is_submit_c && pending_valid)) begin
                    letter       <= pending_letter;
                    letter_valid <= 1'b1;
                end
                submit         <= is_submit_c;
                clear          <= is_clear_c;
                pending_valid  <= 1'b0;
                pending_letter <= '0;
                tap_idx        <= '0;
                tap_timer      <= '0;
            end
        end
    end

endmodule

// File: doc/multitap_keypad_entry.md
Name: multitap_keypad_entry

Overview:
Parametrised matrix-keypad scanner with debounce and multi-tap letter entry, for both host and player consoles of the hangman design. It drives keypad columns, samples rows, and debounces presses. Repeated taps of a letter key cycle through that key's letter group, and the block emits committed ASCII letters plus submit/clear strobes to the game FSMs and a pending-letter preview for the LCD.

Parameters:
NUM_ROWS, 4, keypad rows (2..8)
NUM_COLS, 4, keypad columns (2..8)
SCAN_CYCLES, 2, clocks each column is driven before advancing
DEBOUNCE_CYCLES, 4, consecutive stable samples required for press and for release
TAP_TIMEOUT, 50, idle clocks after a tap before the pending letter auto-commits

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
row_in  in  NUM_ROWS  row sense; bit NUM_ROWS-1 = row 0, active high
col_out  out  NUM_COLS  one-hot column drive; bit NUM_COLS-1 = col 0
letter  out  8  committed ASCII letter, valid only with letter_valid
letter_valid  out  1  one-cycle strobe: letter committed
submit  out  1  one-cycle strobe: submit key pressed
clear  out  1  one-cycle strobe: clear key pressed
pending_letter  out  8  ASCII of the letter currently being tapped
pending_valid  out  1  pending_letter meaningful
key_code  out  $clog2(NUM_ROWS*NUM_COLS)  last debounced key index, row*NUM_COLS+col

Behaviour:
- Reset (synchronous, active-high): col_out = col 0 one-hot; letter = 0, letter_valid = submit = clear = 0; pending_letter = 0, pending_valid = 0; key_code = 0; scan FSM in SCAN; all counters 0. Reset mid-press discards any pending letter with no commit.
- Scan FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- SCAN: drive col c for SCAN_CYCLES, then advance c+1, wrapping NUM_COLS-1 to 0.
  - If exactly one row bit is high on the last cycle of col c's window, latch the row pattern and go to DEBOUNCE. col_out holds.
  - Zero or more than one row bit high means stay in SCAN (multi-key presses are ignored).
- DEBOUNCE: count consecutive cycles with row_in equal to the latched pattern.
  - Reaching DEBOUNCE_CYCLES moves to PRESSED.
  - Any mismatch returns to SCAN with the counter cleared.
- PRESSED: one cycle. Update key_code and raise an internal key event, then go to RELEASE.
- RELEASE: count consecutive cycles with row_in == 0. Reaching DEBOUNCE_CYCLES returns to SCAN at the next column. Any nonzero sample resets the count. No new event is raised while held.
- Key map (package table indexed by key_code):
  - Letter keys 0..7 = ABC, DEF, GHI, JKL, MNO, PQRS, TUV, WXYZ.
  - Key 12 = SUBMIT, key 13 = CLEAR. All other keys are ignored (no event effect).
- Multi-tap, on a letter-key event:
  - Same key as pending, and tap timer < TAP_TIMEOUT: tap index += 1, wrapping modulo group size (3 or 4).
  - Otherwise: commit the old pending letter (if any), then start a new pending with tap index 0.
  - The tap timer clears on every letter event.
- Tap timer: counts while pending_valid. When it reaches TAP_TIMEOUT, commit pending and clear pending_valid.
  - Same-key event in the cycle the timer hits TAP_TIMEOUT: counts as timed out (commit old, start new at index 0).
- SUBMIT event: commit pending if pending_valid, then pulse submit in that same cycle (letter_valid and submit may both be 1). With nothing pending, only submit pulses.
- CLEAR event: drop pending without commit; pulse clear.
- Commit: letter = pending_letter and letter_valid = 1 for one cycle, registered one clock after the commit condition. pending_letter updates one clock after the key event.
- Arithmetic: ASCII = base letter + tap index, 8-bit. Tap timer width = $clog2(TAP_TIMEOUT+1), saturating.

Decomposition:
- Package keypad_pkg holds:
  - scan state enum;
  - key map table of base ASCII and group size per key index;
  - constants KEY_SUBMIT = 12 and KEY_CLEAR = 13.
- Sub-module keypad_scanner covers column drive, debounce and release, and outputs key_event/key_code. The top level holds the multi-tap/commit logic.

Test Plan:
- Reset with row_in = 0 -> col_out = 4'b1000, all strobes 0, pending_valid = 0; columns cycle 1000 -> 0100 -> 0010 -> 0001 -> 1000 every 2 clocks.
- Key 5 (row 1, col 1) tapped once, wait TAP_TIMEOUT -> pending 'P' shown, then a single letter_valid with letter = 8'h50 ('P').
- Key 3 tapped 3 times within timeout, then SUBMIT -> pending goes J, K, L; same-cycle letter_valid ('L', 8'h4C) and submit.
- Key 0 tapped 4 times -> wraps to 'A'. Then key 1 tapped -> 'A' committed at once, pending 'D'. Then CLEAR -> clear pulse, no commit, pending_valid = 0.
- Two rows high together, or a 2-cycle glitch (< DEBOUNCE_CYCLES) -> no key event and key_code unchanged. A key held for 1000 clocks -> exactly one event.
- rst asserted while pending 'E' and in RELEASE -> no letter_valid, all outputs at reset values next clock, and scanning restarts at col 0.
